// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store initiator and its lane logic.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } lsu_state_e;

  // Size 11 has no legal encoding, so it is reported the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = addr_lo[0];
      WORD:    misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Combinational little-endian lane logic: load extraction/extension and store merge.
module mem_lane
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[8*i_offset +: 8];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      BYTE:    o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      HALF:    o_rdata = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_rdata = i_word;
    endcase

    o_merged = i_word;
    case (i_size)
      BYTE: o_merged[8*i_offset +: 8] = i_wdata[7:0];
      HALF: begin
        if (i_offset[1]) o_merged[31:16] = i_wdata;
        else             o_merged[15:0]  = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed RAM; sub-word stores are done as
// read-modify-write since the RAM has no byte enables.
//
// state | meaning
// IDLE  | accepting a request (req_ready=1)
// RD    | read_ram strobe for one cycle
// CAP   | sample ram_out; extend for loads, merge for sub-word stores
// WR    | write_ram strobe for one cycle
// RESP  | response held until rsp_ready
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WORD_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_read_ram,
  output logic        o_write_ram,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_write_data,
  input  logic [31:0] i_ram_out
);

  lsu_state_e  r_state;
  logic        r_req_ready;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_offset;
  logic [15:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_read_ram;
  logic        r_write_ram;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [31:0] w_lane_rdata;
  logic [31:0] w_lane_merged;

  mem_lane u_lane (
    .i_word     (i_ram_out),
    .i_wdata    (r_wdata),
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_rdata    (w_lane_rdata),
    .o_merged   (w_lane_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_offset    <= 2'b00;
      r_wdata     <= 16'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_read_ram  <= 1'b0;
      r_write_ram <= 1'b0;
      r_ram_addr  <= 32'h0;
      r_ram_wdata <= 32'h0;
    end else begin
      r_read_ram  <= 1'b0;
      r_write_ram <= 1'b0;
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          // r_req_ready gates acceptance so nothing is taken in the first cycle after reset.
          if (r_req_ready && i_req_valid) begin
            r_req_ready <= 1'b0;
            r_we        <= i_req_we;
            r_size      <= i_req_size;
            r_unsigned  <= i_req_unsigned;
            r_offset    <= i_req_addr[1:0];
            r_wdata     <= i_req_wdata[15:0];
            r_ram_addr  <= i_req_addr >> WORD_SHIFT;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            if (misaligned(i_req_size, i_req_addr[1:0])) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else if (i_req_we && (i_req_size == WORD)) begin
              r_write_ram <= 1'b1;
              r_ram_wdata <= i_req_wdata;
              r_state     <= WR;
            end else begin
              r_read_ram <= 1'b1;
              r_state    <= RD;
            end
          end
        end
        RD: r_state <= CAP;
        CAP: begin
          if (r_we) begin
            r_write_ram <= 1'b1;
            r_ram_wdata <= w_lane_merged;
            r_state     <= WR;
          end else begin
            r_rsp_rdata <= w_lane_rdata;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        WR: begin
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready      = r_req_ready;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_rdata      = r_rsp_rdata;
  assign o_rsp_err        = r_rsp_err;
  assign o_read_ram       = r_read_ram;
  assign o_write_ram      = r_write_ram;
  assign o_ram_addr       = r_ram_addr;
  assign o_ram_write_data = r_ram_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized requests
// against a byte-lane reference model of the RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic [31:0] i_req_wdata = 32'h0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_read_ram;
  logic        o_write_ram;
  logic [31:0] o_ram_addr;
  logic [31:0] o_ram_write_data;
  logic [31:0] i_ram_out = 32'h0;

  int total = 0;
  int bad = 0;
  int both_cnt = 0;

  logic [31:0] mem   [0:63];
  logic [31:0] model [0:63];

  always #5 clk = ~clk;

  mem_access_unit #(.WORD_SHIFT(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_we         (i_req_we),
    .i_req_size       (i_req_size),
    .i_req_unsigned   (i_req_unsigned),
    .i_req_addr       (i_req_addr),
    .i_req_wdata      (i_req_wdata),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_rsp_err        (o_rsp_err),
    .o_read_ram       (o_read_ram),
    .o_write_ram      (o_write_ram),
    .o_ram_addr       (o_ram_addr),
    .o_ram_write_data (o_ram_write_data),
    .i_ram_out        (i_ram_out)
  );

  // Word-addressed RAM: read data appears the cycle after read_ram.
  always @(posedge clk) begin
    if (o_read_ram) i_ram_out <= mem[o_ram_addr[5:0]];
    if (o_write_ram) mem[o_ram_addr[5:0]] <= o_ram_write_data;
    if (o_read_ram && o_write_ram) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input bit [1:0] size, input bit [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return addr % 2 != 0;
    if (size == 2'd2) return addr % 4 != 0;
    return 1'b0;
  endfunction

  function automatic bit [31:0] ref_load(input bit [31:0] word, input bit [1:0] size,
                                          input int off, input bit uns);
    bit [31:0] v;
    if (size == 2'd0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = (word >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic bit [31:0] ref_store(input bit [31:0] word, input bit [31:0] wdata,
                                           input bit [1:0] size, input int off);
    bit [31:0] mask;
    if (size == 2'd2) return wdata;
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (word & ~mask) | ((wdata << (8 * off)) & mask);
  endfunction

  task automatic do_req(input bit we, input bit [1:0] size, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wdata, input int stall);
    int idx, off, n, rd, wr, wr_cyc, w;
    bit err, got;
    int exp_lat, exp_rd, exp_wr;
    bit [31:0] exp_rdata, exp_wdata;
    idx = int'(addr[7:2]);
    off = int'(addr[1:0]);
    err = ref_err(size, addr);
    exp_rdata = 32'h0;
    exp_wdata = 32'h0;
    if (err) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!we) begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0;
      exp_rdata = ref_load(model[idx], size, off, uns);
    end else if (size == 2'd2) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
      exp_wdata = wdata;
      model[idx] = wdata;
    end else begin
      exp_lat = 4; exp_rd = 1; exp_wr = 1;
      exp_wdata = ref_store(model[idx], wdata, size, off);
      model[idx] = exp_wdata;
    end

    w = 0;
    while (!o_req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", {31'h0, o_req_ready}, 32'h1);
    i_req_valid = 1'b1;
    i_req_we = we;
    i_req_size = size;
    i_req_unsigned = uns;
    i_req_addr = addr;
    i_req_wdata = wdata;
    @(posedge clk);
    #1 i_req_valid = 1'b0;

    n = 0; rd = 0; wr = 0; wr_cyc = 0; got = 1'b0;
    while (n < 12 && !got) begin
      @(negedge clk);
      n++;
      if (o_read_ram) begin
        rd++;
        chk("rd_addr", o_ram_addr, addr >> 2);
      end
      if (o_write_ram) begin
        wr++;
        wr_cyc = n;
        chk("wr_addr", o_ram_addr, addr >> 2);
        chk("wr_data", o_ram_write_data, exp_wdata);
      end
      if (o_rsp_valid) got = 1'b1;
    end
    chk("latency", n, exp_lat);
    chk("rsp_err", {31'h0, o_rsp_err}, {31'h0, err});
    chk("rsp_rdata", o_rsp_rdata, exp_rdata);
    chk("rd_pulses", rd, exp_rd);
    chk("wr_pulses", wr, exp_wr);
    if (exp_wr != 0) chk("wr_cycle", wr_cyc, exp_lat - 1);

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, o_rsp_valid}, 32'h1);
      chk("stall_rdata", o_rsp_rdata, exp_rdata);
      chk("stall_ready", {31'h0, o_req_ready}, 32'h0);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 i_rsp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_hs", {31'h0, o_req_ready}, 32'h1);
    chk("valid_after_hs", {31'h0, o_rsp_valid}, 32'h0);
    if (we && !err) chk("mem_word", mem[idx], model[idx]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] v;
    bit [1:0] sz;
    bit [31:0] a;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      mem[i] <= v;
      model[i] = v;
    end

    #2;
    chk("rst_ready", {31'h0, o_req_ready}, 32'h0);
    chk("rst_valid", {31'h0, o_rsp_valid}, 32'h0);
    chk("rst_strobes", {30'h0, o_read_ram, o_write_ram}, 32'h0);
    chk("rst_addr", o_ram_addr, 32'h0);
    chk("rst_rdata", o_rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_pre_edge", {31'h0, o_req_ready}, 32'h0);
    @(negedge clk);
    chk("ready_post_rel", {31'h0, o_req_ready}, 32'h1);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 0);
    chk("rmw_const", mem[4], 32'h1122AA44);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 5);

    // Reset during CAP of a byte store must leave the RAM word untouched.
    while (!o_req_ready) @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_addr = 32'h21; i_req_wdata = 32'h5A;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {30'h0, o_read_ram, o_write_ram}, 32'h0);
    chk("midrst_valid", {31'h0, o_rsp_valid}, 32'h0);
    chk("midrst_ready", {31'h0, o_req_ready}, 32'h0);
    chk("midrst_wdata", o_ram_write_data, 32'h0);
    chk("midrst_addr", o_ram_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("postrst_valid", {31'h0, o_rsp_valid}, 32'h0);
      chk("postrst_write", {31'h0, o_write_ram}, 32'h0);
    end
    chk("postrst_ready", {31'h0, o_req_ready}, 32'h1);
    chk("postrst_mem", mem[8], model[8]);

    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
        else if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], model[i]);
    chk("both_strobes", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
